keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Upstream input stage for the microwave controller.
- Takes the raw 10-line keypad and qualifies a press only when exactly one key is stable for STABLE_CYCLES clock edges. Presses involving two or more keys are rejected.
- Encodes the accepted key to a BCD digit and shifts it into a 3-digit cooking-time entry register (mins : sec_tens : sec_ones), which the controller loads into its countdown timer.
- Runs on the controller's 100 Hz clock (10 ms period), so the default is a 40 ms qualification window.

Parameters:
- STABLE_CYCLES, 4, number of consecutive edges a single key must be sampled identically before it is accepted (range 2..15).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- keypad  in  10  raw key lines; bit i high = key "i" pressed
- clearn  in  1  active-low synchronous clear of the digit register
- enable  in  1  high = accepted digits are shifted in; low (magnetron running) = digits not stored
- digit  out  4  BCD value of the last accepted key
- digit_valid  out  1  one-cycle pulse per accepted key
- key_error  out  1  one-cycle pulse when a press is rejected as multi-key
- mins  out  4  entry digit 2 (BCD)
- sec_tens  out  4  entry digit 1 (BCD)
- sec_ones  out  4  entry digit 0 (BCD)

Behaviour:
- Input sampling:
  - keypad is registered once into s[9:0]; the FSM acts only on s.
  - One-hot means exactly one bit of s is set. Zero means no bits set. Multi means two or more bits set.
- Reset (synchronous, highest priority): FSM=IDLE, counter=0, candidate=0, s=0, digit=0, digit_valid=0, key_error=0, mins=sec_tens=sec_ones=0.
- FSM states: IDLE, QUALIFY, HELD, REJECT.
- IDLE:
  - s zero: stay.
  - s one-hot: go to QUALIFY; candidate<=s, cnt<=1.
  - s multi: go to REJECT, pulse key_error.
- QUALIFY:
  - s==candidate and cnt==STABLE_CYCLES-1: go to HELD, pulse digit_valid, digit<=index(candidate).
  - s==candidate otherwise: cnt++.
  - s zero: go to IDLE silently (glitch, no pulse).
  - s nonzero and different from candidate: go to REJECT, pulse key_error.
- HELD:
  - Stay until s zero, then go to IDLE.
  - Additional keys pressed while held are ignored (no digit, no error).
- REJECT: stay until s zero, then go to IDLE. No digit is ever produced from a rejected press.
- Latency:
  - A key held across input edges E1..E4 (default STABLE_CYCLES=4) gives digit_valid high for the single cycle following edge E5.
  - A key sampled on only 3 consecutive edges produces nothing.
- Entry register, updated on the same edge that raises digit_valid:
  - With enable=1: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
  - The old mins value is discarded (wrap-around: a 4th digit drops the oldest).
  - With enable=0: digit_valid still pulses and digit still updates; the entry register holds.
- Clear:
  - clearn=0 on an edge sets mins=sec_tens=sec_ones=0.
  - If clear and a shift occur on the same edge, clear wins and the digit is lost.
  - clearn does not affect the FSM.
- Reset mid-operation:
  - Any in-progress qualification is abandoned.
  - A key still held after reset is re-qualified from cnt=1 on the first edge s is one-hot.
- digit_valid and key_error are never high in the same cycle. Each fires at most once per press (press = interval between s leaving zero and returning to zero).

Test Plan:
- Normal entry: keypad=1<<1, 1<<3, 1<<0, each held 50 cycles with 50 idle cycles between, enable=1 → three digit_valid pulses with digit=1,3,0; final mins=1, sec_tens=3, sec_ones=0; key_error never high.
- Glitch rejection: keypad=1<<7 for exactly 3 edges then 0 → no digit_valid, no key_error, register unchanged. Same key held 4 edges → digit_valid on the 5th-edge cycle, digit=7.
- Overlap after acceptance: 1<<5 held 50 cycles, then keypad=10'b0000100010 for 50 cycles, then 0 → exactly one pulse, digit=5; no error; key 1 not entered.
- Overlap during qualification: 1<<5 for 3 cycles, then 10'b0000100010 for 50 cycles, then 0 → key_error one pulse; no digit_valid; register unchanged.
- Wrap and clear: enter 8,5,1,2 → mins=5, sec_tens=1, sec_ones=2. Then clearn=0 for 1 cycle → all 0. clearn=0 on the same edge as a shift of 9 → all 0.
- Enable/reset: enable=0, press 4 → digit_valid, digit=4, register holds. reset=1 mid-QUALIFY for 1 cycle → all outputs 0; the still-held key is accepted 5 edges after reset is released.

Source files
------------

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Purpose  : Debounces and qualifies the raw 10-line keypad. A press is
//            accepted only when exactly one key is seen for STABLE_CYCLES
//            consecutive edges. A press involving two or more keys is
//            rejected. An accepted key becomes a BCD digit and is shifted
//            into a 3-digit cooking-time entry register.
// Ports    : clock       - system clock, rising edge
//            reset       - synchronous active-high reset
//            keypad      - raw key lines, bit i = key "i"
//            clearn      - active-low synchronous clear of the entry register
//            enable      - high: accepted digits shift into the entry register
//            digit       - BCD value of the last accepted key
//            digit_valid - one-cycle pulse per accepted key
//            key_error   - one-cycle pulse per rejected multi-key press
//            mins        - entry digit 2
//            sec_tens    - entry digit 1
//            sec_ones    - entry digit 0
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       clearn,
  input  logic       enable,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       key_error,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam logic [3:0] C_CNT_LAST = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    HELD    = 2'd2,
    REJECT  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [9:0] r_s;
  logic [9:0] r_cand;
  logic [9:0] w_cand_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_accept;
  logic       w_reject;
  logic       w_zero;
  logic       w_onehot;
  logic [3:0] w_index;

  // A value with exactly one bit set clears to zero when ANDed with itself-1.
  assign w_zero   = (r_s == 10'd0);
  assign w_onehot = !w_zero && ((r_s & (r_s - 10'd1)) == 10'd0);

  // Binary index of the one-hot candidate.
  always_comb begin
    w_index = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_cand[i]) w_index = 4'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_next = QUALIFY;
          w_cand_next  = r_s;
          w_cnt_next   = 4'd1;
        end else if (!w_zero) begin
          w_state_next = REJECT;
          w_reject     = 1'b1;
        end
      end
      QUALIFY: begin
        if (r_s == r_cand) begin
          if (r_cnt == C_CNT_LAST) begin
            w_state_next = HELD;
            w_accept     = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end else if (w_zero) begin
          // Released before qualification: treated as a glitch.
          w_state_next = IDLE;
        end else begin
          w_state_next = REJECT;
          w_reject     = 1'b1;
        end
      end
      // Extra keys while held or rejected are ignored until full release.
      HELD, REJECT: begin
        if (w_zero) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_s         <= 10'd0;
      r_cand      <= 10'd0;
      r_cnt       <= 4'd0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_s         <= keypad;
      r_cand      <= w_cand_next;
      r_cnt       <= w_cnt_next;
      digit_valid <= w_accept;
      key_error   <= w_reject;
      if (w_accept) digit <= w_index;
    end
  end

  // Entry register: clear wins over a simultaneous shift.
  always_ff @(posedge clock) begin
    if (reset || !clearn) begin
      mins     <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else if (w_accept && enable) begin
      mins     <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= w_index;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Purpose  : Self-checking bench for keypad_entry. A press-level model
//            predicts every output each cycle; directed scenarios pin the
//            model with literal expectations, then random presses follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

  localparam int STABLE = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       clearn;
  logic       enable;
  logic [3:0] digit;
  logic       digit_valid;
  logic       key_error;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;

  keypad_entry #(.STABLE_CYCLES(STABLE)) dut (
    .clock       (clock),
    .reset       (reset),
    .keypad      (keypad),
    .clearn      (clearn),
    .enable      (enable),
    .digit       (digit),
    .digit_valid (digit_valid),
    .key_error   (key_error),
    .mins        (mins),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking_on = 0;
  int dv_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Press-level model: a press is the span between the sampled keypad
  // leaving zero and returning to zero. Within a press, the first decision
  // wins: STABLE identical one-hot samples accept, anything else rejects.
  // ------------------------------------------------------------------------
  logic [9:0] m_s;
  logic [9:0] m_cand;
  int         m_run;
  bit         m_done;
  logic [3:0] m_digit, m_mins, m_st, m_so;
  bit         m_dv, m_err;

  always @(posedge clock) begin
    if (reset) begin
      m_s = 0; m_cand = 0; m_run = 0; m_done = 0;
      m_digit = 0; m_mins = 0; m_st = 0; m_so = 0;
      m_dv = 0; m_err = 0;
    end else begin
      m_dv = 0;
      m_err = 0;
      if (m_s == 0) begin
        m_run = 0;
        m_done = 0;
      end else if (!m_done) begin
        if ($countones(m_s) == 1 && (m_run == 0 || m_s == m_cand)) begin
          m_cand = m_s;
          m_run++;
          if (m_run == STABLE) begin
            m_dv = 1;
            m_done = 1;
            for (int i = 0; i < 10; i++) if (m_s[i]) m_digit = 4'(i);
          end
        end else begin
          m_err = 1;
          m_done = 1;
        end
      end
      if (!clearn) begin
        m_mins = 0; m_st = 0; m_so = 0;
      end else if (m_dv && enable) begin
        m_mins = m_st; m_st = m_so; m_so = m_digit;
      end
      m_s = keypad;
    end
  end

  always @(negedge clock) begin
    if (checking_on) begin
      chk("digit_valid", int'(digit_valid), int'(m_dv));
      chk("key_error",   int'(key_error),   int'(m_err));
      chk("digit",       int'(digit),       int'(m_digit));
      chk("mins",        int'(mins),        int'(m_mins));
      chk("sec_tens",    int'(sec_tens),    int'(m_st));
      chk("sec_ones",    int'(sec_ones),    int'(m_so));
      if (digit_valid === 1'b1 && key_error === 1'b1) chk("dv_and_err_exclusive", 1, 0);
      if (digit_valid === 1'b1) dv_cnt++;
      if (key_error === 1'b1) err_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input int k, input int hold, input int gap);
    keypad = 10'(1 << k);
    cyc(hold);
    keypad = 10'd0;
    cyc(gap);
  endtask

  task automatic chk_regs(input string tag, input int m, input int t, input int o);
    chk({tag, "_mins"}, int'(mins), m);
    chk({tag, "_sec_tens"}, int'(sec_tens), t);
    chk({tag, "_sec_ones"}, int'(sec_ones), o);
  endtask

  int dv0, err0;

  initial begin
    reset = 1'b1; keypad = 10'd0; clearn = 1'b1; enable = 1'b1;
    cyc(3);
    chk("rst_digit", int'(digit), 0);
    chk("rst_dv", int'(digit_valid), 0);
    chk("rst_err", int'(key_error), 0);
    chk_regs("rst", 0, 0, 0);
    checking_on = 1;
    reset = 1'b0;
    cyc(2);

    // Normal entry 1,3,0
    dv0 = dv_cnt; err0 = err_cnt;
    press(1, 50, 50); press(3, 50, 50); press(0, 50, 50);
    chk("normal_dv_count", dv_cnt - dv0, 3);
    chk("normal_err_count", err_cnt - err0, 0);
    chk("normal_digit", int'(digit), 0);
    chk_regs("normal", 1, 3, 0);

    // Glitch: 3 edges gives nothing, 4 edges accepts
    dv0 = dv_cnt; err0 = err_cnt;
    press(7, 3, 10);
    chk("glitch_dv_count", dv_cnt - dv0, 0);
    chk("glitch_err_count", err_cnt - err0, 0);
    chk_regs("glitch", 1, 3, 0);
    keypad = 10'(1 << 7);
    cyc(4);
    keypad = 10'd0;
    chk("glitch4_dv_early", int'(digit_valid), 0);
    cyc(1);
    chk("glitch4_dv_edge5", int'(digit_valid), 1);
    chk("glitch4_digit", int'(digit), 7);
    cyc(10);
    chk_regs("glitch4", 3, 0, 7);

    // Overlap after acceptance
    dv0 = dv_cnt; err0 = err_cnt;
    keypad = 10'(1 << 5); cyc(50);
    keypad = 10'b0000100010; cyc(50);
    keypad = 10'd0; cyc(10);
    chk("ovl_after_dv", dv_cnt - dv0, 1);
    chk("ovl_after_err", err_cnt - err0, 0);
    chk("ovl_after_digit", int'(digit), 5);
    chk_regs("ovl_after", 0, 7, 5);

    // Overlap during qualification
    dv0 = dv_cnt; err0 = err_cnt;
    keypad = 10'(1 << 5); cyc(3);
    keypad = 10'b0000100010; cyc(50);
    keypad = 10'd0; cyc(10);
    chk("ovl_during_dv", dv_cnt - dv0, 0);
    chk("ovl_during_err", err_cnt - err0, 1);
    chk_regs("ovl_during", 0, 7, 5);

    // Wrap and clear
    press(8, 6, 4); press(5, 6, 4); press(1, 6, 4); press(2, 6, 4);
    chk_regs("wrap", 5, 1, 2);
    clearn = 1'b0; cyc(1); clearn = 1'b1;
    chk_regs("clear", 0, 0, 0);
    dv0 = dv_cnt;
    keypad = 10'(1 << 9); cyc(4);
    clearn = 1'b0; cyc(1); clearn = 1'b1;
    chk("clrshift_dv", int'(digit_valid), 1);
    chk("clrshift_digit", int'(digit), 9);
    chk_regs("clrshift", 0, 0, 0);
    keypad = 10'd0; cyc(5);

    // Enable low: digit updates, register holds
    press(3, 6, 4);
    enable = 1'b0;
    dv0 = dv_cnt;
    press(4, 6, 4);
    chk("en0_dv", dv_cnt - dv0, 1);
    chk("en0_digit", int'(digit), 4);
    chk_regs("en0", 0, 0, 3);
    enable = 1'b1;

    // Reset mid-qualification, key still held
    keypad = 10'(1 << 6); cyc(3);
    reset = 1'b1; cyc(1);
    chk("midrst_dv", int'(digit_valid), 0);
    chk("midrst_digit", int'(digit), 0);
    chk_regs("midrst", 0, 0, 0);
    reset = 1'b0;
    cyc(4);
    chk("midrst_dv_early", int'(digit_valid), 0);
    cyc(1);
    chk("midrst_dv_edge5", int'(digit_valid), 1);
    chk("midrst_digit6", int'(digit), 6);
    keypad = 10'd0; cyc(5);

    // Randomized presses
    for (int p = 0; p < 400; p++) begin
      int kind, hold;
      logic [9:0] kp;
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 8));
      if (kind < 2) kp = 10'd0;
      else if (kind < 8) kp = 10'(1 << $urandom_range(0, 9));
      else kp = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
      enable = ($urandom_range(0, 3) != 0);
      keypad = kp;
      for (int c = 0; c < hold; c++) begin
        clearn = ($urandom_range(0, 15) != 0);
        reset  = ($urandom_range(0, 199) == 0);
        cyc(1);
      end
      clearn = 1'b1;
      reset = 1'b0;
    end
    keypad = 10'd0;
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
